// File: rtl/temperature_monitor_if.sv
// rtl/temperature_monitor_if.sv - sample/alarm bundle between sample source, monitor and status logic
//
// Purpose: groups the temperature sample stream and the qualified alarm
// outputs of temperature_monitor into one interface.
// Signals:
//   i_sample_valid  sample source -> monitor, new sample this cycle
//   i_temperature   sample source -> monitor, unsigned WIDTH-bit sample
//   i_alarm_ack     status logic  -> monitor, clears sticky o_alarm_seen
//   o_abnormal      monitor -> status, last valid sample out of range
//   o_alarm         monitor -> status, qualified alarm
//   o_alarm_high    monitor -> status, last qualifying abnormal was high
//   o_alarm_low     monitor -> status, last qualifying abnormal was low
//   o_alarm_seen    monitor -> status, sticky alarm-entry flag
//   o_event_count   monitor -> status, saturating alarm-entry count
// Modports: master = sample source / status side, slave = monitor.
interface temperature_monitor_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) ();
  logic                 i_sample_valid;
  logic [WIDTH-1:0]     i_temperature;
  logic                 i_alarm_ack;
  logic                 o_abnormal;
  logic                 o_alarm;
  logic                 o_alarm_high;
  logic                 o_alarm_low;
  logic                 o_alarm_seen;
  logic [CNT_WIDTH-1:0] o_event_count;

  modport master (
    output i_sample_valid, i_temperature, i_alarm_ack,
    input  o_abnormal, o_alarm, o_alarm_high, o_alarm_low, o_alarm_seen, o_event_count
  );

  modport slave (
    input  i_sample_valid, i_temperature, i_alarm_ack,
    output o_abnormal, o_alarm, o_alarm_high, o_alarm_low, o_alarm_seen, o_event_count
  );
endinterface

// File: rtl/temperature_monitor.sv
// rtl/temperature_monitor.sv - persistence-qualified temperature alarm with hysteresis recovery
//
// Purpose: classifies each valid sample against LOW_LIMIT/HIGH_LIMIT, raises
// the alarm after PERSIST consecutive abnormal samples and clears it after
// PERSIST consecutive samples inside [LOW_LIMIT+HYST, HIGH_LIMIT-HYST].
// Ports:
//   i_clk    system clock, all state on the rising edge
//   i_reset  synchronous active-high reset
//   mon      temperature_monitor_if.slave (sample in, alarm status out)
// All outputs are registered; invalid cycles hold every piece of state.
module temperature_monitor #(
  parameter int WIDTH      = 8,
  parameter int LOW_LIMIT  = 35,
  parameter int HIGH_LIMIT = 39,
  parameter int HYST       = 1,
  parameter int PERSIST    = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  temperature_monitor_if.slave  mon
);

  localparam int RUN_W = $clog2(PERSIST + 1);

  localparam logic [WIDTH-1:0] LO_TH   = WIDTH'(LOW_LIMIT);
  localparam logic [WIDTH-1:0] HI_TH   = WIDTH'(HIGH_LIMIT);
  localparam logic [WIDTH-1:0] BAND_LO = WIDTH'(LOW_LIMIT + HYST);
  localparam logic [WIDTH-1:0] BAND_HI = WIDTH'(HIGH_LIMIT - HYST);
  localparam logic [RUN_W-1:0] PERSIST_R = RUN_W'(PERSIST);

  typedef enum logic [1:0] {
    S_NORMAL  = 2'd0,
    S_PENDING = 2'd1,
    S_ALARM   = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [RUN_W-1:0]     r_run;
  logic [RUN_W-1:0]     w_run_nxt;
  logic [RUN_W-1:0]     w_run_inc;

  logic                 w_hi;
  logic                 w_lo;
  logic                 w_ab;
  logic                 w_inband;
  logic                 w_entry;
  logic                 w_exit;

  logic                 r_abnormal;
  logic                 r_alarm;
  logic                 r_alarm_high;
  logic                 r_alarm_low;
  logic                 r_alarm_seen;
  logic [CNT_WIDTH-1:0] r_event_count;

  assign w_hi     = mon.i_temperature > HI_TH;
  assign w_lo     = mon.i_temperature < LO_TH;
  assign w_ab     = w_hi | w_lo;
  assign w_inband = (mon.i_temperature >= BAND_LO) && (mon.i_temperature <= BAND_HI);

  // The run counter never exceeds PERSIST-1 while held, so the increment fits.
  assign w_run_inc = r_run + RUN_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_NORMAL;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  // One run counter serves both directions: it counts abnormal samples in
  // PENDING and in-band samples in RECOVER.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_entry     = 1'b0;
    w_exit      = 1'b0;
    if (mon.i_sample_valid) begin
      case (r_state)
        S_NORMAL: begin
          if (w_ab) begin
            if (PERSIST == 1) begin
              w_state_nxt = S_ALARM;
              w_run_nxt   = '0;
              w_entry     = 1'b1;
            end else begin
              w_state_nxt = S_PENDING;
              w_run_nxt   = RUN_W'(1);
            end
          end else begin
            w_run_nxt = '0;
          end
        end
        S_PENDING: begin
          if (w_ab) begin
            if (w_run_inc == PERSIST_R) begin
              w_state_nxt = S_ALARM;
              w_run_nxt   = '0;
              w_entry     = 1'b1;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end else begin
            w_state_nxt = S_NORMAL;
            w_run_nxt   = '0;
          end
        end
        S_ALARM: begin
          if (w_inband) begin
            if (PERSIST == 1) begin
              w_state_nxt = S_NORMAL;
              w_run_nxt   = '0;
              w_exit      = 1'b1;
            end else begin
              w_state_nxt = S_RECOVER;
              w_run_nxt   = RUN_W'(1);
            end
          end else begin
            w_run_nxt = '0;
          end
        end
        S_RECOVER: begin
          if (w_inband) begin
            if (w_run_inc == PERSIST_R) begin
              w_state_nxt = S_NORMAL;
              w_run_nxt   = '0;
              w_exit      = 1'b1;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end else begin
            // Normal-but-outside-band samples also land here and restart recovery.
            w_state_nxt = S_ALARM;
            w_run_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_NORMAL;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_abnormal    <= 1'b0;
      r_alarm       <= 1'b0;
      r_alarm_high  <= 1'b0;
      r_alarm_low   <= 1'b0;
      r_alarm_seen  <= 1'b0;
      r_event_count <= '0;
    end else begin
      if (mon.i_sample_valid) begin
        r_abnormal <= w_ab;
      end
      r_alarm <= (w_state_nxt == S_ALARM) || (w_state_nxt == S_RECOVER);

      if (w_entry) begin
        r_alarm_high <= w_hi;
        r_alarm_low  <= w_lo;
      end else if (w_exit) begin
        r_alarm_high <= 1'b0;
        r_alarm_low  <= 1'b0;
      end else if (mon.i_sample_valid && w_ab &&
                   ((r_state == S_ALARM) || (r_state == S_RECOVER))) begin
        // While alarmed, the direction tracks the most recent abnormal sample.
        r_alarm_high <= w_hi;
        r_alarm_low  <= w_lo;
      end

      // Entry outranks a same-cycle acknowledge so a new alarm is never lost.
      if (w_entry) begin
        r_alarm_seen <= 1'b1;
      end else if (mon.i_alarm_ack) begin
        r_alarm_seen <= 1'b0;
      end

      if (w_entry && (r_event_count != '1)) begin
        r_event_count <= r_event_count + CNT_WIDTH'(1);
      end
    end
  end

  assign mon.o_abnormal    = r_abnormal;
  assign mon.o_alarm       = r_alarm;
  assign mon.o_alarm_high  = r_alarm_high;
  assign mon.o_alarm_low   = r_alarm_low;
  assign mon.o_alarm_seen  = r_alarm_seen;
  assign mon.o_event_count = r_event_count;

endmodule

// File: tb/tb_temperature_monitor.sv
// tb/tb_temperature_monitor.sv - directed self-checking bench for temperature_monitor
module tb_temperature_monitor;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  temperature_monitor_if #(.WIDTH(8), .CNT_WIDTH(8)) mon ();
  temperature_monitor_if #(.WIDTH(8), .CNT_WIDTH(2)) mon2 ();

  temperature_monitor #(.CNT_WIDTH(8)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .mon     (mon.slave)
  );

  temperature_monitor #(.CNT_WIDTH(2)) dut2 (
    .i_clk   (clk),
    .i_reset (reset),
    .mon     (mon2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one valid sample for one cycle; outputs are checked #1 after the edge.
  task automatic send(input bit use2, input logic [7:0] t, input logic ack);
    if (use2) begin
      mon2.i_sample_valid = 1'b1;
      mon2.i_temperature  = t;
      mon2.i_alarm_ack    = ack;
    end else begin
      mon.i_sample_valid = 1'b1;
      mon.i_temperature  = t;
      mon.i_alarm_ack    = ack;
    end
    @(posedge clk);
    #1;
    mon.i_sample_valid  = 1'b0;
    mon.i_alarm_ack     = 1'b0;
    mon2.i_sample_valid = 1'b0;
    mon2.i_alarm_ack    = 1'b0;
  endtask

  task automatic idle(input int n, input logic ack);
    mon.i_alarm_ack = ack;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    mon.i_alarm_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (mon.o_alarm !== 1'b0 || mon.o_abnormal !== 1'b0 || mon.o_alarm_high !== 1'b0 ||
        mon.o_alarm_low !== 1'b0 || mon.o_alarm_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got al=%b ab=%b hi=%b lo=%b seen=%b, want all 0",
               mon.o_alarm, mon.o_abnormal, mon.o_alarm_high, mon.o_alarm_low, mon.o_alarm_seen);
    end
    n_checks++;
    if (mon.o_event_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d want 0", mon.o_event_count);
    end
  endtask

  task automatic test_normal;
    logic [7:0] vals [5];
    vals = '{8'd36, 8'd37, 8'd38, 8'd39, 8'd35};
    for (int i = 0; i < 5; i++) begin
      send(1'b0, vals[i], 1'b0);
      n_checks++;
      if (mon.o_abnormal !== 1'b0 || mon.o_alarm !== 1'b0 || mon.o_event_count !== 8'd0) begin
        n_fail++;
        $display("FAIL normal_%0d: got ab=%b al=%b cnt=%0d want 0/0/0",
                 vals[i], mon.o_abnormal, mon.o_alarm, mon.o_event_count);
      end
    end
  endtask

  task automatic test_high_alarm;
    send(1'b0, 8'd40, 1'b0);
    n_checks++;
    if (mon.o_abnormal !== 1'b1 || mon.o_alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL high_first: got ab=%b al=%b want 1/0", mon.o_abnormal, mon.o_alarm);
    end
    send(1'b0, 8'd40, 1'b0);
    idle(2, 1'b0);
    n_checks++;
    if (mon.o_alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL high_gap: got al=%b want 0", mon.o_alarm);
    end
    send(1'b0, 8'd40, 1'b0);
    n_checks++;
    if (mon.o_alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL high_third: got al=%b want 0", mon.o_alarm);
    end
    send(1'b0, 8'd40, 1'b0);
    n_checks++;
    if (mon.o_alarm !== 1'b1 || mon.o_alarm_high !== 1'b1 || mon.o_alarm_low !== 1'b0 ||
        mon.o_alarm_seen !== 1'b1 || mon.o_event_count !== 8'd1) begin
      n_fail++;
      $display("FAIL high_entry: got al=%b hi=%b lo=%b seen=%b cnt=%0d want 1/1/0/1/1",
               mon.o_alarm, mon.o_alarm_high, mon.o_alarm_low, mon.o_alarm_seen, mon.o_event_count);
    end
  endtask

  task automatic test_recovery;
    logic [7:0] vals [8];
    logic       exp_al [8];
    vals   = '{8'd39, 8'd37, 8'd37, 8'd39, 8'd37, 8'd37, 8'd37, 8'd37};
    exp_al = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      send(1'b0, vals[i], 1'b0);
      n_checks++;
      if (mon.o_alarm !== exp_al[i] || mon.o_abnormal !== 1'b0) begin
        n_fail++;
        $display("FAIL recover_step%0d: got al=%b ab=%b want %b/0",
                 i, mon.o_alarm, mon.o_abnormal, exp_al[i]);
      end
    end
    n_checks++;
    if (mon.o_alarm_high !== 1'b0 || mon.o_alarm_seen !== 1'b1 || mon.o_event_count !== 8'd1) begin
      n_fail++;
      $display("FAIL recover_end: got hi=%b seen=%b cnt=%0d want 0/1/1",
               mon.o_alarm_high, mon.o_alarm_seen, mon.o_event_count);
    end
  endtask

  task automatic test_broken_run;
    logic [7:0] vals [5];
    vals = '{8'd40, 8'd40, 8'd40, 8'd37, 8'd40};
    for (int i = 0; i < 5; i++) begin
      send(1'b0, vals[i], 1'b0);
      n_checks++;
      if (mon.o_alarm !== 1'b0) begin
        n_fail++;
        $display("FAIL broken_step%0d: got al=%b want 0", i, mon.o_alarm);
      end
    end
    // A run of one is pending: two more abnormal samples are not enough, a third is.
    send(1'b0, 8'd40, 1'b0);
    send(1'b0, 8'd40, 1'b0);
    n_checks++;
    if (mon.o_alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL broken_run3: got al=%b want 0", mon.o_alarm);
    end
    send(1'b0, 8'd40, 1'b0);
    n_checks++;
    if (mon.o_alarm !== 1'b1 || mon.o_event_count !== 8'd2) begin
      n_fail++;
      $display("FAIL broken_run4: got al=%b cnt=%0d want 1/2", mon.o_alarm, mon.o_event_count);
    end
    for (int i = 0; i < 4; i++) send(1'b0, 8'd37, 1'b0);
    n_checks++;
    if (mon.o_alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL broken_recover: got al=%b want 0", mon.o_alarm);
    end
  endtask

  task automatic test_low_ack;
    for (int i = 0; i < 3; i++) send(1'b0, 8'd34, 1'b0);
    n_checks++;
    if (mon.o_alarm !== 1'b0 || mon.o_abnormal !== 1'b1) begin
      n_fail++;
      $display("FAIL low_pending: got al=%b ab=%b want 0/1", mon.o_alarm, mon.o_abnormal);
    end
    send(1'b0, 8'd34, 1'b1);
    n_checks++;
    if (mon.o_alarm !== 1'b1 || mon.o_alarm_low !== 1'b1 || mon.o_alarm_high !== 1'b0 ||
        mon.o_alarm_seen !== 1'b1 || mon.o_event_count !== 8'd3) begin
      n_fail++;
      $display("FAIL low_entry_ack: got al=%b lo=%b hi=%b seen=%b cnt=%0d want 1/1/0/1/3",
               mon.o_alarm, mon.o_alarm_low, mon.o_alarm_high, mon.o_alarm_seen, mon.o_event_count);
    end
    idle(1, 1'b1);
    n_checks++;
    if (mon.o_alarm_seen !== 1'b0 || mon.o_alarm !== 1'b1) begin
      n_fail++;
      $display("FAIL low_ack_alone: got seen=%b al=%b want 0/1", mon.o_alarm_seen, mon.o_alarm);
    end
    // A high sample while alarmed flips the reported direction.
    send(1'b0, 8'd45, 1'b0);
    n_checks++;
    if (mon.o_alarm_high !== 1'b1 || mon.o_alarm_low !== 1'b0 || mon.o_event_count !== 8'd3) begin
      n_fail++;
      $display("FAIL low_to_high: got hi=%b lo=%b cnt=%0d want 1/0/3",
               mon.o_alarm_high, mon.o_alarm_low, mon.o_event_count);
    end
    for (int i = 0; i < 4; i++) send(1'b0, 8'd38, 1'b0);
    n_checks++;
    if (mon.o_alarm !== 1'b0 || mon.o_alarm_high !== 1'b0 || mon.o_alarm_low !== 1'b0) begin
      n_fail++;
      $display("FAIL low_recover: got al=%b hi=%b lo=%b want 0/0/0",
               mon.o_alarm, mon.o_alarm_high, mon.o_alarm_low);
    end
  endtask

  task automatic test_reset_mid_run;
    for (int i = 0; i < 3; i++) send(1'b0, 8'd41, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (mon.o_abnormal !== 1'b0 || mon.o_event_count !== 8'd0 || mon.o_alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: got ab=%b cnt=%0d al=%b want 0/0/0",
               mon.o_abnormal, mon.o_event_count, mon.o_alarm);
    end
    send(1'b0, 8'd41, 1'b0);
    n_checks++;
    if (mon.o_alarm !== 1'b0 || mon.o_abnormal !== 1'b1 || mon.o_event_count !== 8'd0) begin
      n_fail++;
      $display("FAIL midrun_after: got al=%b ab=%b cnt=%0d want 0/1/0",
               mon.o_alarm, mon.o_abnormal, mon.o_event_count);
    end
    send(1'b0, 8'd37, 1'b0);
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) send(1'b1, 8'd40, 1'b0);
      n_checks++;
      if (mon2.o_alarm !== 1'b1 || mon2.o_event_count !== exp_cnt[k]) begin
        n_fail++;
        $display("FAIL sat_entry%0d: got al=%b cnt=%0d want 1/%0d",
                 k, mon2.o_alarm, mon2.o_event_count, exp_cnt[k]);
      end
      for (int i = 0; i < 4; i++) send(1'b1, 8'd37, 1'b0);
      n_checks++;
      if (mon2.o_alarm !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_recover%0d: got al=%b want 0", k, mon2.o_alarm);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    mon.i_sample_valid  = 1'b0;
    mon.i_temperature   = 8'd0;
    mon.i_alarm_ack     = 1'b0;
    mon2.i_sample_valid = 1'b0;
    mon2.i_temperature  = 8'd0;
    mon2.i_alarm_ack    = 1'b0;
    test_reset();
    test_normal();
    test_high_alarm();
    test_recovery();
    test_broken_run();
    test_low_ack();
    test_reset_mid_run();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/temperature_monitor.md
# temperature_monitor

Parametrised, clocked successor to the combinational temperature range check. It qualifies each valid temperature sample against configurable low and high limits. An alarm is raised only after a configurable number of consecutive abnormal samples, and cleared only after the same number of consecutive samples inside a hysteresis-narrowed recovery band. It sits between the temperature sample source and the patient-status / display logic, and also provides a sticky alarm flag and a saturating alarm-event counter.

## Interface
- WIDTH, 8: temperature sample width (unsigned).
- LOW_LIMIT, 35: lowest normal temperature; samples < LOW_LIMIT are abnormal-low.
- HIGH_LIMIT, 39: highest normal temperature; samples > HIGH_LIMIT are abnormal-high.
- HYST, 1: recovery band is [LOW_LIMIT+HYST, HIGH_LIMIT-HYST]; constraint LOW_LIMIT+HYST <= HIGH_LIMIT-HYST.
- PERSIST, 4: consecutive samples needed to enter or leave alarm; constraint PERSIST >= 1.
- CNT_WIDTH, 8: width of the alarm-event counter.

Ports:
- clk  in  1  single system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  temperature is a new sample this cycle.
- temperature  in  WIDTH  unsigned sample.
- alarm_ack  in  1  clears the sticky alarm_seen flag.
- abnormal  out  1  registered instantaneous flag for the last valid sample.
- alarm  out  1  qualified alarm (high in ALARM and RECOVER).
- alarm_high  out  1  last qualifying abnormal sample was above HIGH_LIMIT.
- alarm_low  out  1  last qualifying abnormal sample was below LOW_LIMIT.
- alarm_seen  out  1  sticky; set on every NORMAL/PENDING→ALARM entry.
- event_count  out  CNT_WIDTH  number of alarm entries, saturating.

## Operation
- Cycles with sample_valid=0 change nothing: state, counters and outputs hold. Gaps do not break a consecutive run.
- Per valid sample:
  - hi = temperature > HIGH_LIMIT.
  - lo = temperature < LOW_LIMIT.
  - ab = hi | lo.
  - inband = LOW_LIMIT+HYST <= temperature <= HIGH_LIMIT-HYST.
  - All comparisons are unsigned WIDTH-bit.
  - abnormal <= ab.
- A single run counter (width ceil(log2(PERSIST+1))) is shared by PENDING and RECOVER.
- FSM states:
  - NORMAL:
    - ab with PERSIST=1 → ALARM.
    - ab otherwise → PENDING, with run=1.
    - not ab → stay, run=0.
  - PENDING:
    - ab → run+1; when run+1 == PERSIST → ALARM.
    - not ab → NORMAL, run=0.
  - ALARM:
    - inband with PERSIST=1 → NORMAL.
    - inband otherwise → RECOVER, with run=1.
    - else stay, run=0.
    - An ab sample here updates alarm_high/alarm_low.
  - RECOVER:
    - inband → run+1; when run+1 == PERSIST → NORMAL, run=0.
    - not inband → ALARM, run=0.
    - ab → also updates alarm_high/alarm_low.
- A normal sample outside the band (e.g. 35 or 39 with defaults) neither raises nor recovers the alarm. In RECOVER it returns the FSM to ALARM.
- Alarm entry, on the NORMAL/PENDING→ALARM transition:
  - alarm_high <= hi, alarm_low <= lo.
  - alarm_seen <= 1.
  - event_count increments, saturating at 2^CNT_WIDTH-1.
- On return to NORMAL, alarm_high and alarm_low clear to 0. alarm_seen and event_count are unaffected.
- alarm_ack clears alarm_seen on any cycle. If an alarm entry happens in the same cycle, entry wins and alarm_seen = 1.

## Timing
- All outputs are registered. A sample presented with sample_valid in cycle N is reflected in the outputs after the rising edge ending cycle N (1-cycle latency).
- alarm asserts on the edge that accepts the PERSIST-th consecutive abnormal sample. It deasserts on the edge that accepts the PERSIST-th consecutive in-band sample.
- Reset, taking priority over everything, sets on the next edge:
  - state = NORMAL, run = 0.
  - abnormal = alarm = alarm_high = alarm_low = alarm_seen = 0.
  - event_count = 0.
- Reset mid-PENDING or mid-RECOVER discards the partial run; no alarm is raised or retained.
- The inputs temperature and alarm_ack are sampled only on rising edges; there is no combinational path to the outputs.

## Test plan
- Normal samples: reset, then valid samples 36, 37, 38, 39, 35 → abnormal=0, alarm=0, event_count=0 throughout.
- High alarm: four valid 40s, with sample_valid low for 2 cycles between the 2nd and 3rd → abnormal=1 after the first; alarm, alarm_high, alarm_seen = 1 one edge after the 4th; event_count=1; alarm_low=0.
- Broken run: 40, 40, 40, 37, 40 → alarm stays 0; the FSM ends in PENDING with run=1.
- Hysteresis recovery: from ALARM, samples 39, 37, 37, 39, 37, 37, 37, 37 → alarm stays 1 through the 39s. Each 39 (abnormal=0) resets the run; alarm drops one edge after the final 37; alarm_high clears; alarm_seen stays 1.
- Low alarm with simultaneous ack: four 34s with alarm_ack=1 on the 4th sample → alarm_low=1 and alarm_seen=1 (entry wins). A later alarm_ack alone → alarm_seen=0 with alarm still 1.
- Reset and saturation:
  - Three 41s, then reset, then one 41 → alarm never asserts; event_count=0.
  - With CNT_WIDTH=2, five alarm entry/recovery cycles → event_count=3.
